// File: rtl/mem_access_unit.sv
// MAR/MDR owner and SRAM access sequencer for the SLC-3 datapath, with programmable wait states.
// Optional memory-mapped I/O at address 0xFFFF is enabled by defining SLC3_MMIO_EN.
module mem_access_unit #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0]       Bus,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              Mem_Rd,
    input  logic              Mem_Wr,
    output logic [15:0]       MAR,
    output logic [15:0]       MDR,
    output logic              Busy,
    output logic              Mem_Ready,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic [15:0]       Data_from_SRAM,
    output logic [15:0]       Data_to_SRAM,
    output logic              Data_Oe,
    output logic              Mem_CE_n,
    output logic              Mem_OE_n,
    output logic              Mem_WE_n,
    input  logic [15:0]       Switches,
    output logic [15:0]       Hex_Out,
    output logic [2:0]        o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_RD_DONE  = 3'd2,
        S_WR_SETUP = 3'd3,
        S_WR_PULSE = 3'd4,
        S_WR_HOLD  = 3'd5,
        S_WR_DONE  = 3'd6
    } state_t;

    localparam logic [2:0] WS_LAST = WAIT_STATES[2:0];

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_wait;
    logic [15:0] r_mar;
    logic [15:0] r_mdr;
    logic        w_wait_last;
    logic        w_io_sel;
    logic        w_sram_ce;
    logic        w_sram_oe;
    logic        w_sram_we;
    logic        w_drive;

    // The address decode only matters while busy, when MAR is frozen.
`ifdef SLC3_MMIO_EN
    logic [15:0] r_hex;
    assign w_io_sel = (r_mar == 16'hFFFF);
    assign Hex_Out  = r_hex;
`else
    logic w_unused_switches;
    assign w_io_sel          = 1'b0;
    assign Hex_Out           = 16'h0000;
    assign w_unused_switches = ^Switches;
`endif

    assign w_wait_last = (r_wait == WS_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (Mem_Rd) begin
                    w_next_state = S_RD;
                end else if (Mem_Wr) begin
                    w_next_state = S_WR_SETUP;
                end
            end
            S_RD: begin
                if (w_wait_last) begin
                    w_next_state = S_RD_DONE;
                end
            end
            S_RD_DONE:  w_next_state = S_IDLE;
            S_WR_SETUP: w_next_state = S_WR_PULSE;
            S_WR_PULSE: begin
                if (w_wait_last) begin
                    w_next_state = S_WR_HOLD;
                end
            end
            S_WR_HOLD:  w_next_state = S_WR_DONE;
            S_WR_DONE:  w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_sram_ce = 1'b0;
        w_sram_oe = 1'b0;
        w_sram_we = 1'b0;
        w_drive   = 1'b0;
        case (r_state)
            S_RD: begin
                w_sram_ce = 1'b1;
                w_sram_oe = 1'b1;
            end
            S_WR_SETUP, S_WR_HOLD: begin
                w_sram_ce = 1'b1;
                w_drive   = 1'b1;
            end
            S_WR_PULSE: begin
                w_sram_ce = 1'b1;
                w_sram_we = 1'b1;
                w_drive   = 1'b1;
            end
            default: begin
                w_sram_ce = 1'b0;
            end
        endcase
    end

    // I/O accesses keep every SRAM pin idle but follow the same state timing.
    assign Mem_CE_n     = ~(w_sram_ce & ~w_io_sel);
    assign Mem_OE_n     = ~(w_sram_oe & ~w_io_sel);
    assign Mem_WE_n     = ~(w_sram_we & ~w_io_sel);
    assign Data_Oe      = w_drive & ~w_io_sel;
    assign Busy         = (r_state != S_IDLE);
    assign Mem_Ready    = (r_state == S_RD_DONE) || (r_state == S_WR_DONE);
    assign MAR          = r_mar;
    assign MDR          = r_mdr;
    assign Mem_Addr     = r_mar[ADDR_W-1:0];
    assign Data_to_SRAM = r_mdr;
    assign o_dbg_state  = r_state;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_wait  <= 3'd0;
            r_mar   <= 16'h0000;
            r_mdr   <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            // Loads share the request edge, so a new request sees the fresh MAR/MDR.
            if (r_state == S_IDLE) begin
                if (LD_MAR) begin
                    r_mar <= Bus;
                end
                if (LD_MDR) begin
                    r_mdr <= Bus;
                end
            end
            if ((r_state == S_RD) || (r_state == S_WR_PULSE)) begin
                r_wait <= w_wait_last ? 3'd0 : r_wait + 3'd1;
            end
            if ((r_state == S_RD) && w_wait_last) begin
`ifdef SLC3_MMIO_EN
                r_mdr <= w_io_sel ? Switches : Data_from_SRAM;
`else
                r_mdr <= Data_from_SRAM;
`endif
            end
        end
    end

`ifdef SLC3_MMIO_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hex <= 16'h0000;
        end else if ((r_state == S_WR_SETUP) && w_io_sel) begin
            r_hex <= r_mdr;
        end
    end
`endif

endmodule
